// File: rtl/conv1_line_fifo.sv
// conv1_line_fifo: circular line buffer exposing a 3x3 window
// of a raster-scanned image on nine parallel taps.
module conv1_line_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 224
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [9*DATA_WIDTH-1:0] data_out,
  output logic                    full,
  output logic                    empty,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    wr_en,
  input  logic                    rd_en
);

  localparam int DEPTH = 2*IMG_W + 3;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic push, pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  // A pop frees the slot a same-cycle push needs, so full only blocks
  // writes that come without a read.
  always_comb begin
    push    = wr_en && (!full_q || rd_en);
    pop     = rd_en && !empty_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == cnt_t'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[tail_q] <= data_in;
    end
  end

  logic [PW:0] addr;

  always_comb begin
    data_out = '0;
    addr     = '0;
    if (!empty_q) begin
      for (int k = 0; k < 9; k++) begin
        addr = {1'b0, head_q}
             + (PW+1)'((k / 3) * IMG_W + (k % 3));
        if (addr >= (PW+1)'(DEPTH)) begin
          addr = addr - (PW+1)'(DEPTH);
        end
        data_out[k*DATA_WIDTH +: DATA_WIDTH] =
          mem_q[addr[PW-1:0]];
      end
    end
  end

  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_conv1_line_fifo.sv
// tb_conv1_line_fifo: directed checks of fill, overflow, slide,
// streaming wrap, underflow and mid-fill reset.
module tb_conv1_line_fifo;

  localparam int DW    = 16;
  localparam int W     = 224;
  localparam int DEPTH = 2*W + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [9*DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;

  int n_checks = 0;
  int n_fails  = 0;

  conv1_line_fifo #(.DATA_WIDTH(DW), .IMG_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input int i);
    return DW'(16'h0100 + i);
  endfunction

  function automatic logic [DW-1:0] tap(input int k);
    return data_out[k*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [9*DW-1:0] obs,
                       input logic [9*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    #2;

    // reset
    step();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", data_out, '0);
    rst = 1'b1;

    // fill
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = pix(i);
      step();
      check($sformatf("fill_full_%0d", i), full, (i == DEPTH-1));
      check($sformatf("fill_empty_%0d", i), empty, 0);
    end
    wr_en = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("fill_tap%0d", r*3+c), tap(r*3+c),
              pix(r*W + c));

    // overflow ignored
    wr_en   = 1'b1;
    data_in = 16'hBEEF;
    step();
    wr_en = 1'b0;
    check("ovf_full", full, 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("ovf_tap%0d", r*3+c), tap(r*3+c),
              pix(r*W + c));

    // slide by two
    rd_en = 1'b1;
    step();
    step();
    rd_en = 1'b0;
    check("slide_tap0", tap(0), pix(2));
    check("slide_tap3", tap(3), pix(226));
    check("slide_tap6", tap(6), pix(450));
    check("slide_full", full, 0);
    wr_en   = 1'b1;
    data_in = 16'h1234;
    step();
    wr_en = 1'b0;
    check("push1_full", full, 0);
    check("push1_tap7_ram0", tap(7), 16'h1234);
    check("push1_tap0", tap(0), pix(2));
    wr_en   = 1'b1;
    data_in = 16'h5678;
    step();
    wr_en = 1'b0;
    check("push2_full", full, 1);
    check("push2_tap8", tap(8), 16'h5678);
    check("push2_tap7", tap(7), 16'h1234);

    // stream with wrap
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int j = 0; j < 500; j++) begin
      data_in = DW'(16'h2000 + j);
      step();
      check($sformatf("strm_full_%0d", j), full, 1);
      check($sformatf("strm_tap8_%0d", j), tap(8),
            DW'(16'h2000 + j));
      if (j >= DEPTH-1)
        check($sformatf("strm_tap0_%0d", j), tap(0),
              DW'(16'h2000 + j - (DEPTH-1)));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // underflow
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst2_empty", empty, 1);
    check("rst2_dout", data_out, '0);
    rd_en = 1'b1;
    step();
    check("udf_empty", empty, 1);
    check("udf_full", full, 0);
    check("udf_dout", data_out, '0);
    wr_en   = 1'b1;
    data_in = 16'hA5A5;
    step();
    check("udf_wr_empty", empty, 0);
    check("udf_wr_tap0", tap(0), 16'hA5A5);
    wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    check("pop_empty", empty, 1);
    check("pop_dout", data_out, '0);
    wr_en   = 1'b1;
    data_in = 16'h5A5A;
    step();
    wr_en = 1'b0;
    check("repush_tap0", tap(0), 16'h5A5A);

    // reset mid-fill
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = pix(i);
      step();
    end
    wr_en = 1'b0;
    check("part_empty", empty, 0);
    check("part_tap1", tap(1), pix(0));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_dout", data_out, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
